// File: rtl/reverb_param_ramp.sv
// rtl/reverb_param_ramp.sv - round-robin coefficient smoothing scheduler feeding the reverb datapath
// Optional feature macro: PARAM_RAMP_SNAP_EN adds the snap input (jump straight to target).
module reverb_param_ramp #(
  parameter int NUM_CH     = 4,
  parameter int WIDTH      = 25,
  parameter int STEP_SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    sample_tick,
`ifdef PARAM_RAMP_SNAP_EN
  input  logic                    snap,
`endif
  input  logic [NUM_CH*WIDTH-1:0] target_in,
  output logic [NUM_CH*WIDTH-1:0] param_out,
  output logic [NUM_CH-1:0]       settled,
  output logic                    busy,
  output logic                    update_done,
  output logic                    overrun
);

  localparam int               CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]  ONE_CH  = CH_W'(1);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [WIDTH-1:0]  cur_q [NUM_CH];
  logic [WIDTH-1:0]  tgt_q [NUM_CH];
  logic [NUM_CH-1:0] settled_q;
  logic              busy_q, done_q;
  logic              overrun_q, overrun_d;
  logic              accept;
`ifdef PARAM_RAMP_SNAP_EN
  logic              jump_q, jump_d;
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          state_d = ST_SCAN;
          ch_d    = '0;
          accept  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (ch_q == LAST_CH) begin
          state_d = ST_DONE;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + ONE_CH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ticks outside IDLE are dropped, never queued; the sticky flag records the loss.
  assign overrun_d = overrun_q | (sample_tick & (state_q != ST_IDLE));

`ifdef PARAM_RAMP_SNAP_EN
  assign jump_d = accept ? snap : jump_q;
`endif

  logic [WIDTH-1:0] cur_sel, tgt_sel, mag, shifted, ramp_delta, delta, cur_next;
  logic [WIDTH:0]   diff;

  // Shared step unit: one channel per SCAN cycle, delta never exceeds |diff| so no overshoot.
  always_comb begin
    cur_sel    = cur_q[ch_q];
    tgt_sel    = tgt_q[ch_q];
    diff       = {1'b0, tgt_sel} - {1'b0, cur_sel};
    mag        = diff[WIDTH] ? (~diff[WIDTH-1:0] + ONE_W) : diff[WIDTH-1:0];
    shifted    = mag >> STEP_SHIFT;
    ramp_delta = (shifted == '0) ? ONE_W : shifted;
`ifdef PARAM_RAMP_SNAP_EN
    delta      = jump_q ? mag : ramp_delta;
`else
    delta      = ramp_delta;
`endif
    if (mag == '0) begin
      cur_next = cur_sel;
    end else if (diff[WIDTH]) begin
      cur_next = cur_sel - delta;
    end else begin
      cur_next = cur_sel + delta;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      settled_q <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cur_q[i] <= '0;
        tgt_q[i] <= '0;
      end
`ifdef PARAM_RAMP_SNAP_EN
      jump_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      overrun_q <= overrun_d;
`ifdef PARAM_RAMP_SNAP_EN
      jump_q    <= jump_d;
`endif
      if (accept) begin
        for (int i = 0; i < NUM_CH; i++) begin
          tgt_q[i] <= target_in[i*WIDTH +: WIDTH];
        end
      end
      if (state_q == ST_SCAN) begin
        cur_q[ch_q]     <= cur_next;
        settled_q[ch_q] <= (cur_next == tgt_sel);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign param_out[g*WIDTH +: WIDTH] = cur_q[g];
  end

  assign settled     = settled_q;
  assign busy        = busy_q;
  assign update_done = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_reverb_param_ramp.sv
// tb/tb_reverb_param_ramp.sv - self-checking bench for reverb_param_ramp
module tb_reverb_param_ramp;

  localparam int NUM_CH = 4;
  localparam int W      = 25;
  localparam int SHIFT  = 6;
  localparam int PW     = NUM_CH * W;

  logic          clk = 1'b0;
  logic          reset_n_r = 1'b0;
  logic          tick_r = 1'b0;
  logic [PW-1:0] target_r = '0;
`ifdef PARAM_RAMP_SNAP_EN
  logic          snap_r = 1'b0;
`endif
  logic [PW-1:0]     param_out;
  logic [NUM_CH-1:0] settled;
  logic              busy, update_done, overrun;

  always #5 clk = ~clk;

  reverb_param_ramp #(.NUM_CH(NUM_CH), .WIDTH(W), .STEP_SHIFT(SHIFT)) dut (
    .clk        (clk),
    .reset_n    (reset_n_r),
    .sample_tick(tick_r),
`ifdef PARAM_RAMP_SNAP_EN
    .snap       (snap_r),
`endif
    .target_in  (target_r),
    .param_out  (param_out),
    .settled    (settled),
    .busy       (busy),
    .update_done(update_done),
    .overrun    (overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: values per channel, scan start edge, and the spec's timing schedule.
  logic [W-1:0]      m_cur  [NUM_CH];
  logic [W-1:0]      m_snap [NUM_CH];
  logic [W-1:0]      m_new  [NUM_CH];
  logic [NUM_CH-1:0] m_set = '1;
  logic              m_ovr = 1'b0;
  int                m_start = -1000;
  int                edge_no = 0;

  function automatic logic [W-1:0] ramp_step(input logic [W-1:0] c, input logic [W-1:0] t,
                                             input logic jump);
    longint d, m, s;
    d = longint'(t) - longint'(c);
    m = (d < 0) ? -d : d;
    s = m / (longint'(1) << SHIFT);
    if (jump) s = m;
    if (s < 1) s = 1;
    if (m == 0) return c;
    return W'(longint'(c) + ((d > 0) ? s : -s));
  endfunction

  task automatic cycle();
    logic          jmp, exp_busy, exp_done;
    logic [PW-1:0] m_param;
    int            k;
`ifdef PARAM_RAMP_SNAP_EN
    jmp = snap_r;
`else
    jmp = 1'b0;
`endif
    if (!reset_n_r) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_cur[i] = '0;
        m_snap[i] = '0;
      end
      m_set = '1;
      m_ovr = 1'b0;
      m_start = -1000;
    end else begin
      if (tick_r) begin
        if ((edge_no - m_start) >= 1 && (edge_no - m_start) <= NUM_CH + 1) begin
          m_ovr = 1'b1;
        end else begin
          m_start = edge_no;
          for (int i = 0; i < NUM_CH; i++) begin
            m_snap[i] = target_r[i*W +: W];
            m_new[i]  = ramp_step(m_cur[i], m_snap[i], jmp);
          end
        end
      end
      k = edge_no - m_start - 1;
      if (k >= 0 && k < NUM_CH) begin
        m_cur[k] = m_new[k];
        m_set[k] = (m_new[k] == m_snap[k]);
      end
    end
    exp_busy = reset_n_r && (edge_no - m_start) >= 0 && (edge_no - m_start) <= NUM_CH;
    exp_done = reset_n_r && (edge_no - m_start) == NUM_CH;
    for (int i = 0; i < NUM_CH; i++) m_param[i*W +: W] = m_cur[i];
    edge_no++;
    @(posedge clk);
    #1;
    chk($sformatf("cycle%0d", edge_no), {param_out, settled, busy, update_done, overrun},
        {m_param, m_set, exp_busy, exp_done, m_ovr});
  endtask

  task automatic scan();
    tick_r = 1'b1;
    cycle();
    tick_r = 1'b0;
    repeat (NUM_CH + 1) cycle();
  endtask

  task automatic do_reset(input int n);
    reset_n_r = 1'b0;
    tick_r = 1'b0;
    repeat (n) cycle();
    reset_n_r = 1'b1;
  endtask

  typedef struct {
    logic [PW-1:0]     tgt;
    logic [PW-1:0]     param;
    logic [NUM_CH-1:0] set;
  } vec_t;

  vec_t         tbl [7];
  int           done_seen, n;
  logic [W-1:0] prev, cur;
  logic         bad;

  initial begin
    tbl[0] = '{{25'd0, 25'd5, 25'd0, 25'h1000000}, {25'd0, 25'd1, 25'd0, 25'h040000}, 4'b1010};
    tbl[1] = '{{25'd0, 25'd5, 25'd0, 25'h1000000}, {25'd0, 25'd2, 25'd0, 25'h07F000}, 4'b1010};
    tbl[2] = '{{25'd0, 25'd5, 25'h100, 25'h07F000}, {25'd0, 25'd3, 25'd4, 25'h07F000}, 4'b1001};
    tbl[3] = '{{25'd0, 25'd5, 25'h100, 25'h07F000}, {25'd0, 25'd4, 25'd7, 25'h07F000}, 4'b1001};
    tbl[4] = '{{25'd0, 25'd5, 25'h100, 25'h07F000}, {25'd0, 25'd5, 25'd10, 25'h07F000}, 4'b1101};
    tbl[5] = '{{25'd0, 25'd5, 25'h100, 25'h07F000}, {25'd0, 25'd5, 25'd13, 25'h07F000}, 4'b1101};
    tbl[6] = '{{25'h1FFFFFF, 25'd5, 25'd13, 25'h07F000},
               {25'h07FFFF, 25'd5, 25'd13, 25'h07F000}, 4'b0111};

    // Reset with nonzero targets, then idle with no tick.
    target_r = {25'h1234, 25'h55, 25'h1FFFFFF, 25'h1};
    do_reset(3);
    chk("rst param", param_out, '0);
    chk("rst settled", settled, 4'hF);
    chk("rst busy_ovr", {busy, overrun, update_done}, 3'b000);
    repeat (3) cycle();
    chk("idle param", param_out, '0);
    chk("idle settled", settled, 4'hF);

    // Table vectors, back-to-back ticks NUM_CH+2 cycles apart.
    for (int v = 0; v < 7; v++) begin
      target_r = tbl[v].tgt;
      scan();
      chk($sformatf("vec%0d param", v), param_out, tbl[v].param);
      chk($sformatf("vec%0d settled", v), settled, tbl[v].set);
    end
    chk("boundary tick no overrun", overrun, 1'b0);

    // Second tick at E0+2: rejected, single done pulse, one step per channel.
    do_reset(2);
    target_r = {25'd100, 25'd200, 25'd1000, 25'd64};
    done_seen = 0;
    tick_r = 1'b1; cycle();
    tick_r = 1'b0; cycle();
    tick_r = 1'b1; cycle();
    tick_r = 1'b0;
    done_seen += int'(update_done);
    repeat (4) begin
      cycle();
      done_seen += int'(update_done);
    end
    chk("ovr set", overrun, 1'b1);
    chk("ovr one done", done_seen, 1);
    chk("ovr one step", param_out, {25'd1, 25'd3, 25'd15, 25'd1});

    // Reset at E0+3 of a new scan.
    tick_r = 1'b1; cycle();
    tick_r = 1'b0; cycle(); cycle();
    reset_n_r = 1'b0; cycle();
    chk("midrst param", param_out, '0);
    chk("midrst flags", {settled, busy, update_done, overrun}, 7'b1111_000);
    reset_n_r = 1'b1; cycle();
    chk("midrst idle", {busy, update_done}, 2'b00);

    // Tick coinciding with the DONE cycle is rejected.
    target_r = {25'd9, 25'd9, 25'd9, 25'd9};
    tick_r = 1'b1; cycle();
    tick_r = 1'b0;
    repeat (NUM_CH) cycle();
    tick_r = 1'b1; cycle();
    tick_r = 1'b0;
    chk("done tick ovr", overrun, 1'b1);
    cycle();
    chk("done tick ignored", busy, 1'b0);

    // Ramp ch1 up to 0x100, then down to 0 without undershoot.
    do_reset(2);
    target_r = {25'd0, 25'd0, 25'h100, 25'd0};
    n = 0;
    do begin
      scan();
      n++;
    end while (!settled[1] && n < 400);
    chk("up reach", param_out[W +: W], 25'h100);
    target_r = '0;
    scan();
    chk("down first step", param_out[W +: W], 25'h0FC);
    prev = param_out[W +: W];
    bad = 1'b0;
    n = 0;
    while (param_out[W +: W] != '0 && n < 400) begin
      scan();
      cur = param_out[W +: W];
      if (cur > prev) bad = 1'b1;
      prev = cur;
      n++;
    end
    chk("down no wrap", bad, 1'b0);
    chk("down final", {param_out[W +: W], settled[1]}, {25'd0, 1'b1});

    // Randomized traffic against the model.
    do_reset(2);
    for (int c = 0; c < 1500; c++) begin
      reset_n_r = ($urandom_range(0, 299) != 0);
      tick_r = ($urandom_range(0, 3) == 0);
`ifdef PARAM_RAMP_SNAP_EN
      snap_r = ($urandom_range(0, 5) == 0);
`endif
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < NUM_CH; i++) begin
          target_r[i*W +: W] = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
        end
      end
      cycle();
    end
    reset_n_r = 1'b1;
    tick_r = 1'b0;

`ifdef PARAM_RAMP_SNAP_EN
    do_reset(2);
    target_r = {25'd7, 25'h1FFFFFF, 25'd0, 25'h123456};
    snap_r = 1'b1; tick_r = 1'b1; cycle();
    snap_r = 1'b0; tick_r = 1'b0;
    repeat (NUM_CH) cycle();
    chk("snap param", param_out, {25'd7, 25'h1FFFFFF, 25'd0, 25'h123456});
    chk("snap settled", settled, 4'hF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
